// File: rtl/alu_seq_pkg.sv
// Shared opcodes, FSM state type and flag helper for the sequential ALU.
// ALU_SEQ_DIV_EN only affects decode in alu_seq; the constants are always present.
package alu_seq_pkg;

  localparam logic [3:0] OpAnd  = 4'b0000;
  localparam logic [3:0] OpOr   = 4'b0001;
  localparam logic [3:0] OpAdd  = 4'b0010;
  localparam logic [3:0] OpSub  = 4'b0110;
  localparam logic [3:0] OpSlt  = 4'b0111;
  localparam logic [3:0] OpMul  = 4'b1000;
  localparam logic [3:0] OpDivu = 4'b1001;
  localparam logic [3:0] OpRemu = 4'b1010;
  localparam logic [3:0] OpNor  = 4'b1100;
  localparam logic [3:0] OpXor  = 4'b1101;

  typedef enum logic [1:0] {StIdle, StMul, StDiv, StDone} state_e;

  // Two's-complement overflow from operand and result sign bits.
  function automatic logic signed_ovf(logic a_msb, logic b_msb, logic r_msb, logic is_sub);
    if (is_sub) return (a_msb != b_msb) && (r_msb != a_msb);
    return (a_msb == b_msb) && (r_msb != a_msb);
  endfunction

endpackage

// File: rtl/alu_seq_if.sv
// Operand/result handshake bundle between the decode stage, alu_seq and writeback.
interface alu_seq_if #(
  parameter int unsigned WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [3:0]       op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             carry_out;
  logic             overflow;
  logic             illegal;
  logic             busy;

  modport master (
    output in_valid, a, b, op, out_ready,
    input  in_ready, out_valid, result, zero, carry_out, overflow, illegal, busy
  );

  modport slave (
    input  in_valid, a, b, op, out_ready,
    output in_ready, out_valid, result, zero, carry_out, overflow, illegal, busy
  );
endinterface

// File: rtl/alu_seq_iter.sv
// Iterative engine: shift-add multiply or restoring divide, one bit per cycle.
// acc_o/shr_o expose the next-state values so the final step lands in the caller's registers.
module alu_seq_iter #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned MUL_CYCLES = WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic             div_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             done_o,
  output logic [WIDTH-1:0] acc_o,
  output logic [WIDTH-1:0] shr_o
);

  localparam int unsigned CntW = $clog2(MUL_CYCLES);

  logic             run_q, div_q;
  logic [CntW-1:0]  cnt_q;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] shr_q, shr_d;
  logic [WIDTH:0]   trial, trial_sub;

  // Divide: acc is the partial remainder, shr shifts the dividend out and the quotient in.
  assign trial     = {acc_q, shr_q[WIDTH-1]};
  assign trial_sub = trial - {1'b0, mcand_q};

  always_comb begin
    acc_d   = acc_q;
    mcand_d = mcand_q;
    shr_d   = shr_q;
    if (div_q) begin
      if (!trial_sub[WIDTH]) begin
        acc_d = trial_sub[WIDTH-1:0];
        shr_d = {shr_q[WIDTH-2:0], 1'b1};
      end else begin
        acc_d = trial[WIDTH-1:0];
        shr_d = {shr_q[WIDTH-2:0], 1'b0};
      end
    end else begin
      acc_d   = acc_q + (shr_q[0] ? mcand_q : '0);
      mcand_d = mcand_q << 1;
      shr_d   = shr_q >> 1;
    end
  end

  assign done_o = run_q && (cnt_q == CntW'(MUL_CYCLES - 1));
  assign acc_o  = acc_d;
  assign shr_o  = shr_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q   <= 1'b0;
      div_q   <= 1'b0;
      cnt_q   <= '0;
      acc_q   <= '0;
      mcand_q <= '0;
      shr_q   <= '0;
    end else if (start_i) begin
      run_q   <= 1'b1;
      div_q   <= div_i;
      cnt_q   <= '0;
      acc_q   <= '0;
      mcand_q <= b_i;
      shr_q   <= a_i;
    end else if (run_q) begin
      acc_q   <= acc_d;
      mcand_q <= mcand_d;
      shr_q   <= shr_d;
      cnt_q   <= cnt_q + 1'b1;
      if (done_o) run_q <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Handshaked ALU: registered single-cycle ops plus iterative MUL (and DIVU/REMU when
// ALU_SEQ_DIV_EN is defined); holds its output while the consumer stalls.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned MUL_CYCLES = WIDTH
) (
  input logic       clk,
  input logic       rst_n,
  alu_seq_if.slave  bus
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d, carry_q, carry_d, ovf_q, ovf_d, ill_q, ill_d;
  logic             out_valid_q, out_valid_d;
  logic [3:0]       op_q, op_d;

  logic             accept, is_div, is_iter, iter_start, iter_done;
  logic [WIDTH-1:0] acc_next, shr_next, iter_res;
  logic [WIDTH-1:0] alu_res;
  logic             alu_c, alu_v, alu_ill;
  logic [WIDTH:0]   sum, diff;

`ifdef ALU_SEQ_DIV_EN
  assign is_div = (bus.op == OpDivu) || (bus.op == OpRemu);
`else
  assign is_div = 1'b0;
`endif
  assign is_iter = (bus.op == OpMul) || is_div;

  assign bus.in_ready = (state_q == StIdle) && (!out_valid_q || bus.out_ready);
  assign accept       = bus.in_valid && bus.in_ready;

  assign sum  = {1'b0, bus.a} + {1'b0, bus.b};
  assign diff = {1'b0, bus.a} - {1'b0, bus.b};

  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    alu_ill = 1'b0;
    case (bus.op)
      OpAnd: alu_res = bus.a & bus.b;
      OpOr:  alu_res = bus.a | bus.b;
      OpNor: alu_res = ~(bus.a | bus.b);
      OpXor: alu_res = bus.a ^ bus.b;
      OpAdd: begin
        alu_res = sum[WIDTH-1:0];
        alu_c   = sum[WIDTH];
        alu_v   = signed_ovf(bus.a[WIDTH-1], bus.b[WIDTH-1], sum[WIDTH-1], 1'b0);
      end
      OpSub: begin
        alu_res = diff[WIDTH-1:0];
        alu_c   = ~diff[WIDTH];
        alu_v   = signed_ovf(bus.a[WIDTH-1], bus.b[WIDTH-1], diff[WIDTH-1], 1'b1);
      end
      OpSlt: begin
        alu_res = {{(WIDTH-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
        alu_c   = ~diff[WIDTH];
      end
      default: alu_ill = 1'b1;
    endcase
  end

  alu_seq_iter #(
    .WIDTH      (WIDTH),
    .MUL_CYCLES (MUL_CYCLES)
  ) u_iter (
    .clk     (clk),
    .rst_n   (rst_n),
    .start_i (iter_start),
    .div_i   (is_div),
    .a_i     (bus.a),
    .b_i     (bus.b),
    .done_o  (iter_done),
    .acc_o   (acc_next),
    .shr_o   (shr_next)
  );

  assign iter_res = (op_q == OpDivu) ? shr_next : acc_next;

  always_comb begin
    state_d     = state_q;
    result_d    = result_q;
    zero_d      = zero_q;
    carry_d     = carry_q;
    ovf_d       = ovf_q;
    ill_d       = ill_q;
    out_valid_d = out_valid_q;
    op_d        = op_q;
    iter_start  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (out_valid_q && bus.out_ready) out_valid_d = 1'b0;
        if (accept) begin
          op_d = bus.op;
          if (is_iter) begin
            iter_start = 1'b1;
            state_d    = is_div ? StDiv : StMul;
          end else begin
            result_d    = alu_res;
            zero_d      = (alu_res == '0);
            carry_d     = alu_c;
            ovf_d       = alu_v;
            ill_d       = alu_ill;
            out_valid_d = 1'b1;
          end
        end
      end
      StMul, StDiv: begin
        if (iter_done) begin
          result_d    = iter_res;
          zero_d      = (iter_res == '0);
          carry_d     = 1'b0;
          ovf_d       = 1'b0;
          ill_d       = 1'b0;
          out_valid_d = 1'b1;
          state_d     = StDone;
        end
      end
      StDone: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      result_q    <= '0;
      zero_q      <= 1'b0;
      carry_q     <= 1'b0;
      ovf_q       <= 1'b0;
      ill_q       <= 1'b0;
      out_valid_q <= 1'b0;
      op_q        <= '0;
    end else begin
      state_q     <= state_d;
      result_q    <= result_d;
      zero_q      <= zero_d;
      carry_q     <= carry_d;
      ovf_q       <= ovf_d;
      ill_q       <= ill_d;
      out_valid_q <= out_valid_d;
      op_q        <= op_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.zero      = zero_q;
  assign bus.carry_out = carry_q;
  assign bus.overflow  = ovf_q;
  assign bus.illegal   = ill_q;
  assign bus.busy      = (state_q == StMul) || (state_q == StDiv);

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: directed corner cases then randomized traffic with
// random back-pressure, checked against an arithmetic reference model.
module tb_alu_seq;
  import alu_seq_pkg::*;

  localparam int unsigned W = 32;

  typedef struct packed {
    logic         vld;
    logic [W-1:0] res;
    logic         z, c, v, i;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   ready_mode = 0;  // 0: ready, 1: stalled, 2: random
  exp_t sb[$];

  alu_seq_if #(.WIDTH(W)) bus ();

  alu_seq #(
    .WIDTH      (W),
    .MUL_CYCLES (W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic exp_t model(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t              e;
    longint            sx, sy, s;
    longint unsigned   ux, uy, p;
    e = '0;
    e.vld = 1'b1;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = x;
    uy = y;
    case (o)
      4'b0000: e.res = x & y;
      4'b0001: e.res = x | y;
      4'b1100: e.res = ~(x | y);
      4'b1101: e.res = x ^ y;
      4'b0010: begin
        s = sx + sy;
        p = ux + uy;
        e.res = p[W-1:0];
        e.c = (p >> W) != 0;
        e.v = s != longint'($signed(e.res));
      end
      4'b0110: begin
        s = sx - sy;
        e.res = x - y;
        e.c = (x >= y);
        e.v = s != longint'($signed(e.res));
      end
      4'b0111: begin
        e.res = (sx < sy) ? 1 : 0;
        e.c = (x >= y);
      end
      4'b1000: begin
        p = ux * uy;
        e.res = p[W-1:0];
      end
`ifdef ALU_SEQ_DIV_EN
      4'b1001: e.res = (y == 0) ? '1 : x / y;
      4'b1010: e.res = (y == 0) ? x : x % y;
`endif
      default: e.i = 1'b1;
    endcase
    e.z = (e.res == 0);
    return e;
  endfunction

  // Back-pressure driver; updates 2 time units after each rising edge.
  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      case (ready_mode)
        0:       bus.out_ready = 1'b1;
        1:       bus.out_ready = 1'b0;
        default: bus.out_ready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  // Monitor: pops on every output handshake, checks hold stability while stalled.
  initial begin
    exp_t got, held, e;
    logic held_v;
    held_v = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        held_v = 1'b0;
      end else begin
        got = {bus.out_valid, bus.result, bus.zero, bus.carry_out, bus.overflow, bus.illegal};
        if (held_v) chk("hold_stable", 64'(got), 64'(held));
        held_v = 1'b0;
        if (bus.busy) chk("busy_blocks_in_ready", 64'(bus.in_ready), 64'(0));
        if (bus.out_valid) begin
          if (!bus.out_ready) begin
            held_v = 1'b1;
            held   = got;
          end else if (sb.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_output: got %0h expected no output", got);
          end else begin
            e = sb.pop_front();
            chk("result_flags", 64'(got), 64'(e));
          end
        end
      end
    end
  end

  // Present an op from posedge+1; pushes the expectation on the cycle it is accepted.
  task automatic issue(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                       output int acc_cyc);
    int n;
    n = 0;
    acc_cyc = -1;
    bus.in_valid = 1'b1;
    bus.op = o;
    bus.a = x;
    bus.b = y;
    while (1) begin
      @(negedge clk);
      if (bus.in_ready) begin
        sb.push_back(model(o, x, y));
        acc_cyc = cyc;
        @(posedge clk);
        #1;
        break;
      end
      n++;
      if (n > 300) begin
        chk("accept_timeout", 64'(0), 64'(1));
        @(posedge clk);
        #1;
        break;
      end
    end
  endtask

  // Counts falling edges after the accept edge until out_valid.
  task automatic wait_valid(input bit iter, output int lat);
    lat = 0;
    while (1) begin
      @(negedge clk);
      lat++;
      if (bus.out_valid) break;
      if (iter) chk("iter_busy_ready", 64'({bus.busy, bus.in_ready}), 64'(2'b10));
      if (lat > 200) begin
        chk("valid_timeout", 64'(0), 64'(1));
        break;
      end
    end
  endtask

  task automatic run_one(input string nm, input logic [3:0] o, input logic [W-1:0] x,
                         input logic [W-1:0] y, input bit iter, input int exp_lat,
                         input logic [W-1:0] exp_res, input logic exp_ill);
    int c0, lat;
    issue(o, x, y, c0);
    bus.in_valid = 1'b0;
    wait_valid(iter, lat);
    chk({nm, "_latency"}, 64'(lat), 64'(exp_lat));
    chk({nm, "_result"}, 64'(bus.result), 64'(exp_res));
    chk({nm, "_illegal"}, 64'(bus.illegal), 64'(exp_ill));
    @(posedge clk);
    #1;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, c1, lat, k;
    logic [3:0] o;
    logic [W-1:0] x, y;
    bus.in_valid = 1'b0;
    bus.op = '0;
    bus.a = '0;
    bus.b = '0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    @(negedge clk);
    chk("rst_out_valid", 64'(bus.out_valid), 64'(0));
    chk("rst_busy", 64'(bus.busy), 64'(0));
    chk("rst_result", 64'(bus.result), 64'(0));
    chk("rst_flags", 64'({bus.zero, bus.carry_out, bus.overflow, bus.illegal}), 64'(0));
    chk("rst_in_ready", 64'(bus.in_ready), 64'(1));
    @(posedge clk);
    #1;

    run_one("add_max", OpAdd, 32'h7FFF_FFFF, 32'h1, 1'b0, 1, 32'h8000_0000, 1'b0);
    run_one("sub_0_1", OpSub, 32'h0, 32'h1, 1'b0, 1, 32'hFFFF_FFFF, 1'b0);

    // Back-to-back SUB then SLT.
    issue(OpSub, 32'd5, 32'd5, c0);
    issue(OpSlt, 32'hFFFF_FFFF, 32'd1, c1);
    bus.in_valid = 1'b0;
    chk("b2b_throughput", 64'(c1 - c0), 64'(1));
    wait_valid(1'b0, lat);
    chk("slt_latency", 64'(lat), 64'(1));
    chk("slt_result", 64'(bus.result), 64'(1));
    @(posedge clk);
    #1;

    run_one("mul", OpMul, 32'd1234, 32'd5678, 1'b1, W + 1, 32'd7006652, 1'b0);
    run_one("mul_zero", OpMul, 32'hDEAD_BEEF, 32'd0, 1'b1, W + 1, 32'd0, 1'b0);

    // Output stalled for three cycles with the next op waiting.
    issue(OpAdd, 32'h11, 32'h22, c0);
    ready_mode = 1;
    bus.op = OpAnd;
    bus.a = 32'hF0;
    bus.b = 32'h3C;
    repeat (3) begin
      @(negedge clk);
      chk("stall_in_ready", 64'(bus.in_ready), 64'(0));
      chk("stall_result", 64'(bus.result), 64'(32'h33));
      @(posedge clk);
      #1;
    end
    ready_mode = 0;
    @(negedge clk);
    chk("stall_release_ready", 64'(bus.in_ready), 64'(1));
    if (bus.in_ready) sb.push_back(model(OpAnd, 32'hF0, 32'h3C));
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    wait_valid(1'b0, lat);
    chk("after_stall_latency", 64'(lat), 64'(1));
    chk("after_stall_result", 64'(bus.result), 64'(32'h30));
    @(posedge clk);
    #1;

    // Reset in the middle of a multiply.
    issue(OpMul, $urandom, $urandom | 32'h1, c0);
    bus.in_valid = 1'b0;
    repeat (10) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_outs", 64'({bus.out_valid, bus.busy, bus.result, bus.zero, bus.carry_out,
                            bus.overflow, bus.illegal}), 64'(0));
    sb.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("midrst_no_valid", 64'(bus.out_valid), 64'(0));
    end
    @(posedge clk);
    #1;
    run_one("and_after_rst", OpAnd, 32'hF0, 32'h3C, 1'b0, 1, 32'h30, 1'b0);

    run_one("illegal_0011", 4'b0011, 32'h1234, 32'h5678, 1'b0, 1, 32'h0, 1'b1);
`ifdef ALU_SEQ_DIV_EN
    run_one("divu_by0", OpDivu, 32'd100, 32'd0, 1'b1, W + 1, 32'hFFFF_FFFF, 1'b0);
    run_one("remu_100_7", OpRemu, 32'd100, 32'd7, 1'b1, W + 1, 32'd2, 1'b0);
`else
    run_one("divu_illegal", OpDivu, 32'd100, 32'd7, 1'b0, 1, 32'h0, 1'b1);
`endif

    // Randomized traffic with random back-pressure.
    ready_mode = 2;
    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 9))
        0: o = OpAnd;
        1: o = OpOr;
        2: o = OpAdd;
        3: o = OpSub;
        4: o = OpSlt;
        5: o = OpNor;
        6: o = OpXor;
        7: o = OpMul;
        default: o = 4'($urandom);
      endcase
      for (int j = 0; j < 2; j++) begin
        case ($urandom_range(0, 5))
          0: x = '0;
          1: x = '1;
          2: x = 32'h7FFF_FFFF;
          3: x = 32'h8000_0000;
          4: x = $urandom_range(0, 15);
          default: x = $urandom;
        endcase
        if (j == 0) y = x;
      end
      issue(o, y, x, c0);
      k = $urandom_range(0, 2);
      if (k != 0) begin
        bus.in_valid = 1'b0;
        repeat (k) @(posedge clk);
        #1;
      end
    end
    bus.in_valid = 1'b0;
    ready_mode = 0;
    k = 0;
    while (sb.size() != 0 && k < 200) begin
      @(posedge clk);
      k++;
    end
    @(negedge clk);
    chk("drain_empty", 64'(sb.size()), 64'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
